// File: rtl/rcas_pkg.sv
// Shared types and sizing helpers for the sequential ripple-carry adder/subtractor.
package rcas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk build still needs a one-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcas_seq_if.sv
// Operand/result handshake bundle for rcas_seq: valid/ready in, valid/ready out.
interface rcas_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/rca_chunk.sv
// Combinational CHUNK-wide ripple adder built from gate-level full adders;
// also exposes the carry into the top bit so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb;
    logic g;
    logic p;

    xor u_x0 (axb, a, b);
    xor u_x1 (s, axb, cin);
    and u_a0 (g, a, b);
    and u_a1 (p, axb, cin);
    or  u_o0 (cout, g, p);
endmodule

module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (c[gi]),
                .s    (s[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/rcas_seq.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB chunk first.
// Define RCAS_SEQ_SAT_EN to saturate the result to the signed limit on overflow.
module rcas_seq
    import rcas_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic       clk,
    input logic       rst,
    rcas_seq_if.slave bus
);
    localparam int             NCHUNK   = nchunk(WIDTH, CHUNK);
    localparam int             CW       = cnt_width(NCHUNK);
    localparam logic [CW-1:0]  LAST_CNT = CW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_cfg
            $fatal(1, "rcas_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic             c_msb;
    logic             ovf_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_next;

    assign a_chunk = a_reg[cnt_reg*CHUNK +: CHUNK];
    assign b_chunk = b_reg[cnt_reg*CHUNK +: CHUNK];

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .cin      (carry_reg),
        .s        (s_chunk),
        .cout     (c_out),
        .c_msb_in (c_msb)
    );

    always_comb begin
        acc_next = acc_reg;
        acc_next[cnt_reg*CHUNK +: CHUNK] = s_chunk;
    end

    // Only meaningful while the top chunk is in the adder.
    assign ovf_next = c_msb ^ c_out;

`ifdef RCAS_SEQ_SAT_EN
    // On overflow both operands share a sign, so A's MSB gives the true result's sign.
    always_comb begin
        result_next = acc_next;
        if (ovf_next) begin
            result_next = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign result_next = acc_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b ^ {WIDTH{bus.mode}};
                        carry_reg <= (bus.mode == MODE_SUB);
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= c_out;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        sum_reg       <= result_next;
                        cout_reg      <= c_out;
                        ovf_reg       <= ovf_next;
                        zero_reg      <= (result_next == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;

endmodule
